param_digital_lock: RTL and testbench

Parametrised successor to the five-button digital lock: N one-hot keys, configurable code length, runtime-programmable code, failed-attempt lockout, entry timeout and timed auto-relock. Sits between the debounced button inputs and the display/actuator logic. Status outputs (digit_cnt, fail_cnt, lockout) feed the existing seven-segment driver. The display driver is out of scope.

---
 rtl/param_digital_lock_pkg.sv | 21 ++
 rtl/param_digital_lock_key_press_detect.sv | 33 +++
 rtl/param_digital_lock.sv | 153 +++++++++++++++
 tb/tb_param_digital_lock.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_digital_lock_pkg.sv
// Shared types and helpers for the parametrised digital lock.
package param_digital_lock_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_ENTRY,
    ST_OPEN,
    ST_PROG,
    ST_LOCKOUT
  } state_e;

  localparam int unsigned MAX_CODE_BITS = 256;

  // Digit idx of a packed code, digit 0 in the least significant slot.
  function automatic logic [7:0] code_digit(input logic [MAX_CODE_BITS-1:0] code,
                                            input int unsigned idx,
                                            input int unsigned dw);
    return 8'(code >> (idx * dw)) & 8'((32'd1 << dw) - 32'd1);
  endfunction

endpackage

// File: rtl/param_digital_lock_key_press_detect.sv
// Rising-edge detector over the key bus; flags multi-key rises as invalid.
module key_press_detect #(
  parameter int unsigned NUM_KEYS = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_KEYS-1:0]         key_i,
  output logic                        press_o,
  output logic                        invalid_o,
  output logic [$clog2(NUM_KEYS)-1:0] digit_o
);

  localparam int unsigned DW = $clog2(NUM_KEYS);

  logic [NUM_KEYS-1:0] key_q;
  logic [NUM_KEYS-1:0] rise;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) key_q <= '0;
    else         key_q <= key_i;
  end

  always_comb begin
    rise      = key_i & ~key_q;
    press_o   = |rise;
    invalid_o = |(rise & (rise - NUM_KEYS'(1)));
    digit_o   = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (rise[NUM_KEYS-1-i]) digit_o = DW'(NUM_KEYS-1-i);
    end
  end

endmodule

// File: rtl/param_digital_lock.sv
// Digital lock: code entry, lockout, timed relock and runtime code programming.
module param_digital_lock
  import param_digital_lock_pkg::*;
#(
  parameter int unsigned NUM_KEYS = 5,
  parameter int unsigned CODE_LEN = 4,
  parameter logic [CODE_LEN*$clog2(NUM_KEYS)-1:0] DEFAULT_CODE = 12'h0D1,
  parameter int unsigned MAX_TRIES = 3,
  parameter logic [31:0] LOCKOUT_CYCLES = 32'd100_000_000,
  parameter logic [31:0] UNLOCK_CYCLES  = 32'd500_000_000,
  parameter logic [31:0] ENTRY_TIMEOUT  = 32'd300_000_000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_KEYS-1:0]              key,
  input  logic                             prog_en,
  output logic                             unlock,
  output logic                             lock,
  output logic                             lockout,
  output logic                             err,
  output logic                             code_updated,
  output logic [$clog2(CODE_LEN+1)-1:0]    digit_cnt,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt
);

  localparam int unsigned DW = $clog2(NUM_KEYS);
  localparam int unsigned CB = CODE_LEN * DW;
  localparam int unsigned CW = $clog2(CODE_LEN + 1);
  localparam int unsigned FW = $clog2(MAX_TRIES + 1);

  state_e          state_q;
  logic [CB-1:0]   code_q, shadow_q, shadow_d;
  logic [CW-1:0]   dcnt_q;
  logic [FW-1:0]   fcnt_q;
  logic            mism_q, err_q, upd_q;
  logic [31:0]     timer_q, timer_d;
  logic            press, invalid;
  logic [DW-1:0]   digit;
  logic [7:0]      exp_digit;
  logic            mismatch_now;

  key_press_detect #(.NUM_KEYS(NUM_KEYS)) u_kpd (
    .clk_i    (clk),
    .rst_ni   (reset),
    .key_i    (key),
    .press_o  (press),
    .invalid_o(invalid),
    .digit_o  (digit)
  );

  always_comb begin
    timer_d      = (timer_q == '1) ? timer_q : timer_q + 32'd1;
    exp_digit    = code_digit(MAX_CODE_BITS'(code_q), 32'(dcnt_q), DW);
    mismatch_now = invalid || (8'(digit) != exp_digit);
    shadow_d     = shadow_q;
    if (32'(dcnt_q) < CODE_LEN) shadow_d[32'(dcnt_q)*DW +: DW] = digit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_LOCKED;
      code_q   <= DEFAULT_CODE;
      shadow_q <= '0;
      dcnt_q   <= '0;
      fcnt_q   <= '0;
      mism_q   <= 1'b0;
      timer_q  <= '0;
      err_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      err_q   <= 1'b0;
      upd_q   <= 1'b0;
      timer_q <= timer_d;
      unique case (state_q)
        ST_LOCKED: if (press) begin
          dcnt_q  <= CW'(1);
          mism_q  <= mismatch_now;
          timer_q <= '0;
          state_q <= ST_ENTRY;
        end
        ST_ENTRY: begin
          // Evaluate cycle takes priority; a press landing here is dropped.
          if (32'(dcnt_q) == CODE_LEN) begin
            dcnt_q  <= '0;
            timer_q <= '0;
            if (!mism_q) begin
              fcnt_q  <= '0;
              state_q <= ST_OPEN;
            end else begin
              err_q   <= 1'b1;
              fcnt_q  <= fcnt_q + 1'b1;
              state_q <= (32'(fcnt_q) + 32'd1 == MAX_TRIES) ? ST_LOCKOUT : ST_LOCKED;
            end
          end else if (press) begin
            dcnt_q  <= dcnt_q + 1'b1;
            mism_q  <= mism_q || mismatch_now;
            timer_q <= '0;
          end else if (timer_q >= ENTRY_TIMEOUT - 32'd1) begin
            dcnt_q  <= '0;
            timer_q <= '0;
            state_q <= ST_LOCKED;
          end
        end
        ST_OPEN: begin
          if (prog_en) begin
            dcnt_q  <= '0;
            timer_q <= '0;
            state_q <= ST_PROG;
          end else if (timer_q >= UNLOCK_CYCLES - 32'd1) begin
            timer_q <= '0;
            state_q <= ST_LOCKED;
          end
        end
        ST_PROG: begin
          timer_q <= timer_q;
          if (!prog_en || (press && invalid)) begin
            dcnt_q  <= '0;
            timer_q <= '0;
            state_q <= ST_OPEN;
          end else if (press) begin
            if (32'(dcnt_q) == CODE_LEN - 1) begin
              code_q  <= shadow_d;
              upd_q   <= 1'b1;
              dcnt_q  <= '0;
              timer_q <= '0;
              state_q <= ST_LOCKED;
            end else begin
              shadow_q <= shadow_d;
              dcnt_q   <= dcnt_q + 1'b1;
            end
          end
        end
        ST_LOCKOUT: if (timer_q >= LOCKOUT_CYCLES - 32'd1) begin
          fcnt_q  <= '0;
          timer_q <= '0;
          state_q <= ST_LOCKED;
        end
        default: state_q <= ST_LOCKED;
      endcase
    end
  end

  always_comb begin
    unlock       = (state_q == ST_OPEN) || (state_q == ST_PROG);
    lock         = ~unlock;
    lockout      = (state_q == ST_LOCKOUT);
    err          = err_q;
    code_updated = upd_q;
    digit_cnt    = dcnt_q;
    fail_cnt     = fcnt_q;
  end

endmodule

// File: tb/tb_param_digital_lock.sv
// Scoreboard bench for param_digital_lock with shortened timeouts.
module tb_param_digital_lock;

  localparam int unsigned NK  = 5;
  localparam int unsigned CL  = 4;
  localparam int unsigned MT  = 3;
  localparam int unsigned UNL = 100;
  localparam int unsigned LKO = 50;
  localparam int unsigned ETO = 200;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NK-1:0] key = '0;
  logic          prog_en = 1'b0;
  logic          unlock, lock, lockout, err, code_updated;
  logic [2:0]    digit_cnt;
  logic [1:0]    fail_cnt;

  always #5 clk = ~clk;

  param_digital_lock #(
    .NUM_KEYS      (NK),
    .CODE_LEN      (CL),
    .DEFAULT_CODE  (12'h0D1),
    .MAX_TRIES     (MT),
    .LOCKOUT_CYCLES(32'(LKO)),
    .UNLOCK_CYCLES (32'(UNL)),
    .ENTRY_TIMEOUT (32'(ETO))
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key         (key),
    .prog_en     (prog_en),
    .unlock      (unlock),
    .lock        (lock),
    .lockout     (lockout),
    .err         (err),
    .code_updated(code_updated),
    .digit_cnt   (digit_cnt),
    .fail_cnt    (fail_cnt)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {EV_ERR, EV_UPD, EV_LKO_RISE, EV_LKO_FALL, EV_UNL_RISE, EV_UNL_FALL} ev_e;
  typedef struct { ev_e kind; int unsigned at; int fails; } ev_t;
  typedef struct { int unsigned at; int dcnt; int fails; } probe_t;
  ev_t    exp_q[$];
  probe_t probe_q[$];

  int checks = 0;
  int errors = 0;

  // Behavioural model state: stored code digits and consecutive failures.
  int m_code[CL];
  int m_fails;
  int unsigned last_e;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input ev_e k, input int unsigned at, input int f);
    ev_t e;
    e.kind = k; e.at = at; e.fails = f;
    exp_q.push_back(e);
  endtask

  task automatic push_probe(input int unsigned at, input int d, input int f);
    probe_t p;
    p.at = at; p.dcnt = d; p.fails = f;
    probe_q.push_back(p);
  endtask

  task automatic seen_ev(input ev_e k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got %s at cyc %0d, required no event", k.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.at != cyc || (e.fails >= 0 && e.fails != int'(fail_cnt))) begin
        errors++;
        $display("FAIL event: got %s at cyc %0d fail_cnt=%0d, required %s at cyc %0d fail_cnt=%0d",
                 k.name(), cyc, fail_cnt, e.kind.name(), e.at, e.fails);
      end
    end
  endtask

  logic p_unl = 1'b0;
  logic p_lko = 1'b0;

  always @(negedge clk) begin
    probe_t p;
    if (reset) begin
      chk("lock_inverse", int'(lock), int'(!unlock));
      if (err === 1'b1)          seen_ev(EV_ERR);
      if (code_updated === 1'b1) seen_ev(EV_UPD);
      if (lockout && !p_lko)     seen_ev(EV_LKO_RISE);
      if (!lockout && p_lko)     seen_ev(EV_LKO_FALL);
      if (unlock && !p_unl)      seen_ev(EV_UNL_RISE);
      if (!unlock && p_unl)      seen_ev(EV_UNL_FALL);
      while (probe_q.size() > 0 && probe_q[0].at <= cyc) begin
        p = probe_q.pop_front();
        chk("probe_at", int'(cyc), int'(p.at));
        chk("probe_digit_cnt", int'(digit_cnt), p.dcnt);
        chk("probe_fail_cnt", int'(fail_cnt), p.fails);
      end
    end
    p_unl = unlock;
    p_lko = lockout;
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  // One-cycle key pulse; last_e is the edge that captured it.
  task automatic press_mask(input logic [NK-1:0] m, input bit prog_last);
    @(negedge clk);
    key = m;
    if (prog_last) begin
      push_ev(EV_UPD, cyc + 1, -1);
      push_ev(EV_UNL_FALL, cyc + 1, -1);
    end
    @(negedge clk);
    key = '0;
    last_e = cyc;
  endtask

  task automatic attempt(input int d[CL], input bit stay_open);
    bit match;
    int unsigned e0;
    match = 1'b1;
    for (int i = 0; i < int'(CL); i++) begin
      if (d[i] < 0) begin
        press_mask(NK'(6), 1'b0);
        match = 1'b0;
      end else begin
        press_mask(NK'(1) << d[i], 1'b0);
        if (d[i] != m_code[i]) match = 1'b0;
      end
      if (i < int'(CL) - 1) idle($urandom_range(0, 3));
    end
    e0 = last_e;
    if (match) begin
      m_fails = 0;
      push_ev(EV_UNL_RISE, e0 + 1, 0);
      if (stay_open) wait_until(e0 + 2);
      else begin
        push_ev(EV_UNL_FALL, e0 + 1 + UNL, 0);
        wait_until(e0 + 1 + UNL + 2);
      end
    end else begin
      m_fails++;
      push_ev(EV_ERR, e0 + 1, m_fails);
      if (m_fails == int'(MT)) begin
        push_ev(EV_LKO_RISE, e0 + 1, int'(MT));
        push_ev(EV_LKO_FALL, e0 + 1 + LKO, 0);
        m_fails = 0;
        while (cyc + 10 < e0 + LKO) press_mask(NK'($urandom_range(1, 31)), 1'b0);
        wait_until(e0 + 1 + LKO + 2);
      end else begin
        wait_until(e0 + 2);
      end
    end
  endtask

  task automatic program_code(input int nd[CL]);
    attempt(m_code, 1'b1);
    @(negedge clk);
    prog_en = 1'b1;
    for (int i = 0; i < int'(CL); i++) begin
      press_mask(NK'(1) << nd[i], i == int'(CL) - 1);
      idle($urandom_range(0, 2));
    end
    m_code = nd;
    wait_until(last_e + 2);
    prog_en = 1'b0;
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int d[CL];
    int unsigned e0;
    m_code = '{1, 2, 3, 0};
    m_fails = 0;

    #1;
    chk("rst_unlock", int'(unlock), 0);
    chk("rst_lock", int'(lock), 1);
    chk("rst_lockout", int'(lockout), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_code_updated", int'(code_updated), 0);
    chk("rst_digit_cnt", int'(digit_cnt), 0);
    chk("rst_fail_cnt", int'(fail_cnt), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(2);

    attempt('{1, 2, 3, 0}, 1'b0);
    attempt('{1, 2, 4, 0}, 1'b0);
    attempt('{0, 0, 0, 0}, 1'b0);
    attempt('{3, 2, 1, 0}, 1'b0);
    attempt('{1, 2, 3, 0}, 1'b0);

    // Programming aborted by dropping prog_en, then a real reprogram.
    attempt(m_code, 1'b1);
    @(negedge clk);
    prog_en = 1'b1;
    press_mask(NK'(1) << 4, 1'b0);
    press_mask(NK'(1) << 4, 1'b0);
    @(negedge clk);
    prog_en = 1'b0;
    e0 = cyc + 1;
    push_ev(EV_UNL_FALL, e0 + UNL, -1);
    wait_until(e0 + UNL + 2);
    program_code('{4, 4, 0, 1});
    attempt('{1, 2, 3, 0}, 1'b0);
    attempt('{4, 4, 0, 1}, 1'b0);

    // Entry timeout after two digits.
    press_mask(NK'(1) << m_code[0], 1'b0);
    press_mask(NK'(1) << m_code[1], 1'b0);
    e0 = last_e;
    push_probe(e0 + 1, 2, m_fails);
    push_probe(e0 + ETO - 1, 2, m_fails);
    push_probe(e0 + ETO, 0, m_fails);
    wait_until(e0 + ETO + 2);
    attempt(m_code, 1'b0);

    attempt('{-1, 2, 3, 0}, 1'b0);

    // A held key counts once and then the entry times out.
    @(negedge clk);
    key = NK'(1) << 1;
    e0 = cyc + 1;
    push_probe(e0, 1, m_fails);
    push_probe(e0 + ETO - 1, 1, m_fails);
    push_probe(e0 + ETO, 0, m_fails);
    idle(1000);
    key = '0;
    idle(3);

    for (int it = 0; it < 14; it++) begin
      case ($urandom_range(0, 3))
        0: attempt(m_code, 1'b0);
        1: begin
          for (int i = 0; i < int'(CL); i++) d[i] = int'($urandom_range(0, NK - 1));
          attempt(d, 1'b0);
        end
        2: begin
          d = m_code;
          d[$urandom_range(0, CL - 1)] = -1;
          attempt(d, 1'b0);
        end
        default: begin
          attempt(m_code, 1'b1);
          e0 = last_e;
          repeat (4) press_mask(NK'($urandom_range(1, 31)), 1'b0);
          push_ev(EV_UNL_FALL, e0 + 1 + UNL, -1);
          wait_until(e0 + 1 + UNL + 2);
        end
      endcase
    end

    // Reset in the middle of programming restores the default code.
    attempt(m_code, 1'b1);
    @(negedge clk);
    prog_en = 1'b1;
    press_mask(NK'(1) << 2, 1'b0);
    press_mask(NK'(1) << 3, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_prog_reset_lock", int'(lock), 1);
    chk("mid_prog_reset_unlock", int'(unlock), 0);
    chk("mid_prog_reset_digit_cnt", int'(digit_cnt), 0);
    chk("mid_prog_reset_fail_cnt", int'(fail_cnt), 0);
    prog_en = 1'b0;
    m_code = '{1, 2, 3, 0};
    m_fails = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(2);
    attempt('{1, 2, 3, 0}, 1'b0);

    idle(5);
    chk("pending_events", exp_q.size() + probe_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
